// File: rtl/nonogram_pkg.sv
// Shared types and record-layout helpers for the solver line FIFO producer.
// Defaults here match the line_record_packer parameter defaults.
package nonogram_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      EMIT    = 2'd2
   } state_t;

   localparam int SIZE_DEF     = 3;
   localparam int MAX_OPTS_DEF = 64;
   localparam int IDX_W_DEF    = 5;
   localparam int CNT_W_DEF    = 7;
   localparam int REC_W_DEF    = 1024;

   // Header is is_row, then line_idx, then the option count; options follow.
   localparam int OPT_BASE = 1 + IDX_W_DEF + CNT_W_DEF;
   localparam int REC_USED = OPT_BASE + MAX_OPTS_DEF * SIZE_DEF;

   function automatic int rec_slot_lsb(input int k,
                                       input int opt_base = OPT_BASE,
                                       input int size     = SIZE_DEF);
      return opt_base + k * size;
   endfunction

endpackage

// File: rtl/line_record_packer_if.sv
// Option-in / FIFO-out bundle of line_record_packer.
// Carries known_mask/known_val only when PACKER_KNOWN_FILTER_EN is defined.
interface line_record_packer_if #(
   parameter int SIZE  = 3,
   parameter int IDX_W = 5,
   parameter int CNT_W = 7,
   parameter int REC_W = 1024
);

   logic             start;
   logic             is_row;
   logic [IDX_W-1:0] line_idx;
   logic             opt_valid;
   logic [SIZE-1:0]  opt_in;
   logic             opt_last;
   logic             opt_ready;
   logic             fifo_full;
   logic             fifo_wr;
   logic [REC_W-1:0] fifo_din;
   logic [CNT_W-1:0] opt_count;
   logic             busy;
   logic             overflow;
`ifdef PACKER_KNOWN_FILTER_EN
   logic [SIZE-1:0]  known_mask;
   logic [SIZE-1:0]  known_val;
`endif

   // master is the enumerator/FIFO side, slave is the packer itself.
   modport master (
`ifdef PACKER_KNOWN_FILTER_EN
      output known_mask, known_val,
`endif
      output start, is_row, line_idx, opt_valid, opt_in, opt_last, fifo_full,
      input  opt_ready, fifo_wr, fifo_din, opt_count, busy, overflow
   );

   modport slave (
`ifdef PACKER_KNOWN_FILTER_EN
      input  known_mask, known_val,
`endif
      input  start, is_row, line_idx, opt_valid, opt_in, opt_last, fifo_full,
      output opt_ready, fifo_wr, fifo_din, opt_count, busy, overflow
   );

endinterface

// File: rtl/line_record_packer_filter.sv
// Known-cell consistency test used when PACKER_KNOWN_FILTER_EN is defined;
// an option is kept only if it agrees with every known cell.
`ifdef PACKER_KNOWN_FILTER_EN
module opt_known_filter #(
   parameter int SIZE = 3
) (
   input  logic [SIZE-1:0] opt_i,
   input  logic [SIZE-1:0] mask_i,
   input  logic [SIZE-1:0] val_i,
   output logic            keep_o
);

   assign keep_o = (((opt_i ^ val_i) & mask_i) == '0);

endmodule
`endif

// File: rtl/line_record_packer.sv
// Packs the candidate options of one board line into a single record for the line FIFO.
// Optional known-cell filtering is enabled with PACKER_KNOWN_FILTER_EN.
module line_record_packer
   import nonogram_pkg::*;
#(
   parameter int SIZE     = SIZE_DEF,
   parameter int MAX_OPTS = MAX_OPTS_DEF,
   parameter int IDX_W    = IDX_W_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int REC_W    = REC_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   line_record_packer_if.slave lrp
);

   localparam int SLOT_BASE = 1 + IDX_W + CNT_W;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPTS);

   generate
      if (SLOT_BASE + MAX_OPTS * SIZE > REC_W) begin : g_rec_too_small
         $error("line_record_packer: REC_W too small for header plus MAX_OPTS options");
      end
      if ((64'd1 << CNT_W) <= 64'(MAX_OPTS)) begin : g_cnt_too_small
         $error("line_record_packer: CNT_W cannot represent MAX_OPTS");
      end
   endgenerate

   state_t           state_q, state_d;
   logic [REC_W-1:0] rec_q, rec_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             optKeep;
   logic             handshake;

`ifdef PACKER_KNOWN_FILTER_EN
   logic [SIZE-1:0]  known_mask_q, known_val_q;

   // Known cells belong to the line being collected, so they are latched with the header.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         known_mask_q <= '0;
         known_val_q  <= '0;
      end else if (state_q == IDLE && lrp.start) begin
         known_mask_q <= lrp.known_mask;
         known_val_q  <= lrp.known_val;
      end
   end

   opt_known_filter #(.SIZE(SIZE)) u_filter (
      .opt_i  (lrp.opt_in),
      .mask_i (known_mask_q),
      .val_i  (known_val_q),
      .keep_o (optKeep)
   );
`else
   assign optKeep = 1'b1;
`endif

   assign handshake = lrp.opt_valid && (state_q == COLLECT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rec_q      <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rec_q      <= rec_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rec_d      = rec_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      case (state_q)
         IDLE: begin
            if (lrp.start) begin
               state_d            = COLLECT;
               rec_d              = '0;
               rec_d[0]           = lrp.is_row;
               rec_d[IDX_W:1]     = lrp.line_idx;
               count_d            = '0;
            end
         end
         COLLECT: begin
            if (handshake) begin
               // A full record still completes the handshake so the enumerator never stalls.
               if (optKeep) begin
                  if (count_q == MAX_CNT) begin
                     overflow_d = 1'b1;
                  end else begin
                     rec_d   = rec_q | (REC_W'(lrp.opt_in)
                               << rec_slot_lsb(int'(count_q), SLOT_BASE, SIZE));
                     count_d = count_q + 1'b1;
                  end
               end
               if (lrp.opt_last) begin
                  state_d = EMIT;
               end
            end
         end
         EMIT: begin
            if (!lrp.fifo_full) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      rec_d[SLOT_BASE-CNT_W +: CNT_W] = count_d;
   end

   assign lrp.opt_ready = (state_q == COLLECT);
   assign lrp.busy      = (state_q != IDLE);
   assign lrp.fifo_wr   = (state_q == EMIT) && !lrp.fifo_full;
   assign lrp.fifo_din  = rec_q;
   assign lrp.opt_count = count_q;
   assign lrp.overflow  = overflow_q;

endmodule

// File: tb/tb_line_record_packer.sv
// Directed bench for line_record_packer: a default-sized instance and a MAX_OPTS=4
// instance run side by side on the same stimulus. Filter test needs PACKER_KNOWN_FILTER_EN.
`timescale 1ns/1ps
module tb_line_record_packer;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       isRow = 1'b0;
   logic [4:0] lineIdx = '0;
   logic       optValid = 1'b0;
   logic [2:0] optIn = '0;
   logic       optLast = 1'b0;
   logic       fifoFull = 1'b0;
`ifdef PACKER_KNOWN_FILTER_EN
   logic [2:0] knownMask = '0;
   logic [2:0] knownVal  = '0;
`endif

   int checks = 0;
   int errors = 0;

   logic [1023:0] recsA[$];
   logic [31:0]   recsB[$];

   always #5 clk = ~clk;

   line_record_packer_if #(.SIZE(3), .IDX_W(5), .CNT_W(7), .REC_W(1024)) ifA ();
   line_record_packer_if #(.SIZE(3), .IDX_W(5), .CNT_W(3), .REC_W(32))   ifB ();

   assign ifA.start = start;       assign ifB.start = start;
   assign ifA.is_row = isRow;      assign ifB.is_row = isRow;
   assign ifA.line_idx = lineIdx;  assign ifB.line_idx = lineIdx;
   assign ifA.opt_valid = optValid; assign ifB.opt_valid = optValid;
   assign ifA.opt_in = optIn;      assign ifB.opt_in = optIn;
   assign ifA.opt_last = optLast;  assign ifB.opt_last = optLast;
   assign ifA.fifo_full = fifoFull; assign ifB.fifo_full = fifoFull;
`ifdef PACKER_KNOWN_FILTER_EN
   assign ifA.known_mask = knownMask; assign ifB.known_mask = knownMask;
   assign ifA.known_val  = knownVal;  assign ifB.known_val  = knownVal;
`endif

   line_record_packer dutA (
      .clk   (clk),
      .rst_n (rst_n),
      .lrp   (ifA)
   );

   line_record_packer #(.MAX_OPTS(4), .CNT_W(3), .REC_W(32)) dutB (
      .clk   (clk),
      .rst_n (rst_n),
      .lrp   (ifB)
   );

   // Every write strobe is logged mid-cycle so each pulse is seen exactly once.
   always @(negedge clk) begin
      if (ifA.fifo_wr === 1'b1) recsA.push_back(ifA.fifo_din);
      if (ifB.fifo_wr === 1'b1) recsB.push_back(ifB.fifo_din);
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired got running want finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic startLine(input logic row, input logic [4:0] idx);
      @(negedge clk);
      start = 1'b1; isRow = row; lineIdx = idx;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic sendOpt(input logic [2:0] o, input logic last);
      int waited = 0;
      optValid = 1'b1; optIn = o; optLast = last;
      while (ifA.opt_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 20) begin
         errors++;
         $display("[TB] FAIL opt_ready_timeout got 0 want 1");
      end
      @(negedge clk);
      optValid = 1'b0; optLast = 1'b0;
   endtask

   task automatic waitIdle();
      int n = 0;
      while ((ifA.busy !== 1'b0 || ifB.busy !== 1'b0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         errors++;
         $display("[TB] FAIL idle_timeout got busy want idle");
      end
   endtask

   task automatic test_reset();
      #12;
      checks++; if ({ifA.fifo_wr, ifA.opt_ready, ifA.busy, ifA.overflow} !== 4'b0) begin
         errors++; $display("[TB] FAIL reset_flags_a got %b want 0000", {ifA.fifo_wr, ifA.opt_ready, ifA.busy, ifA.overflow}); end
      checks++; if ({ifB.fifo_wr, ifB.opt_ready, ifB.busy, ifB.overflow} !== 4'b0) begin
         errors++; $display("[TB] FAIL reset_flags_b got %b want 0000", {ifB.fifo_wr, ifB.opt_ready, ifB.busy, ifB.overflow}); end
      checks++; if (ifA.opt_count !== 7'd0 || ifA.fifo_din !== '0) begin
         errors++; $display("[TB] FAIL reset_data_a got count %0d din_nonzero %0b want 0", ifA.opt_count, |ifA.fifo_din); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      recsA.delete(); recsB.delete();
      fifoFull = 1'b0;
      startLine(1'b1, 5'd1);
      sendOpt(3'b100, 1'b0);
      sendOpt(3'b010, 1'b0);
      sendOpt(3'b001, 1'b1);
      checks++; if (ifA.fifo_wr !== 1'b1 || ifB.fifo_wr !== 1'b1) begin
         errors++; $display("[TB] FAIL basic_latency got %b%b want 11", ifA.fifo_wr, ifB.fifo_wr); end
      checks++; if (ifA.opt_count !== 7'd3) begin
         errors++; $display("[TB] FAIL basic_count got %0d want 3", ifA.opt_count); end
      waitIdle();
      checks++; if (recsA.size() !== 1 || recsB.size() !== 1) begin
         errors++; $display("[TB] FAIL basic_wr_pulses got %0d/%0d want 1/1", recsA.size(), recsB.size()); end
      checks++; if ((recsA.size() > 0 ? recsA[0] : '0) !== 1024'hA80C3) begin
         errors++; $display("[TB] FAIL basic_record_a got %h want a80c3", (recsA.size() > 0 ? recsA[0] : '0)); end
      checks++; if ((recsB.size() > 0 ? recsB[0] : '0) !== 32'hA8C3) begin
         errors++; $display("[TB] FAIL basic_record_b got %h want 0000a8c3", (recsB.size() > 0 ? recsB[0] : '0)); end
   endtask

   task automatic test_backpressure();
      logic lowOk = 1'b1;
      recsA.delete(); recsB.delete();
      startLine(1'b1, 5'd1);
      sendOpt(3'b100, 1'b0);
      sendOpt(3'b010, 1'b0);
      fifoFull = 1'b1;
      sendOpt(3'b001, 1'b1);
      repeat (5) begin
         if (ifA.fifo_wr !== 1'b0 || ifB.fifo_wr !== 1'b0 || ifA.busy !== 1'b1) lowOk = 1'b0;
         @(posedge clk); #1;
      end
      checks++; if (lowOk !== 1'b1) begin
         errors++; $display("[TB] FAIL bp_hold got strobe_or_idle want held_low"); end
      fifoFull = 1'b0;
      waitIdle();
      checks++; if (recsA.size() !== 1 || recsB.size() !== 1) begin
         errors++; $display("[TB] FAIL bp_wr_pulses got %0d/%0d want 1/1", recsA.size(), recsB.size()); end
      checks++; if ((recsA.size() > 0 ? recsA[0] : '0) !== 1024'hA80C3) begin
         errors++; $display("[TB] FAIL bp_record_a got %h want a80c3", (recsA.size() > 0 ? recsA[0] : '0)); end
      checks++; if ((recsB.size() > 0 ? recsB[0] : '0) !== 32'hA8C3) begin
         errors++; $display("[TB] FAIL bp_record_b got %h want 0000a8c3", (recsB.size() > 0 ? recsB[0] : '0)); end
   endtask

   task automatic test_overflow();
      recsA.delete(); recsB.delete();
      startLine(1'b0, 5'd3);
      sendOpt(3'b001, 1'b0);
      sendOpt(3'b010, 1'b0);
      sendOpt(3'b011, 1'b0);
      sendOpt(3'b100, 1'b0);
      sendOpt(3'b101, 1'b0);
      sendOpt(3'b110, 1'b1);
      waitIdle();
      checks++; if (ifB.opt_count !== 3'd4 || ifB.overflow !== 1'b1) begin
         errors++; $display("[TB] FAIL ovf_small got count %0d ovf %b want 4 1", ifB.opt_count, ifB.overflow); end
      checks++; if (ifA.opt_count !== 7'd6 || ifA.overflow !== 1'b0) begin
         errors++; $display("[TB] FAIL ovf_large got count %0d ovf %b want 6 0", ifA.opt_count, ifA.overflow); end
      checks++; if ((recsB.size() > 0 ? recsB[0] : '0) !== 32'h11A306) begin
         errors++; $display("[TB] FAIL ovf_record_b got %h want 0011a306", (recsB.size() > 0 ? recsB[0] : '0)); end
      checks++; if ((recsA.size() > 0 ? recsA[0] : '0) !== 1024'h6B1A2186) begin
         errors++; $display("[TB] FAIL ovf_record_a got %h want 6b1a2186", (recsA.size() > 0 ? recsA[0] : '0)); end
   endtask

   task automatic test_reset_mid();
      recsA.delete(); recsB.delete();
      startLine(1'b1, 5'd7);
      sendOpt(3'b101, 1'b0);
      sendOpt(3'b110, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++; if ({ifA.opt_ready, ifA.busy, ifA.fifo_wr} !== 3'b0 || ifA.opt_count !== 7'd0 || ifA.fifo_din !== '0) begin
         errors++; $display("[TB] FAIL midrst_a got rdy%b busy%b cnt%0d want all 0", ifA.opt_ready, ifA.busy, ifA.opt_count); end
      checks++; if ({ifB.opt_ready, ifB.busy, ifB.overflow} !== 3'b0 || ifB.fifo_din !== '0) begin
         errors++; $display("[TB] FAIL midrst_b got rdy%b busy%b ovf%b din %h want all 0", ifB.opt_ready, ifB.busy, ifB.overflow, ifB.fifo_din); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (recsA.size() !== 0 || recsB.size() !== 0) begin
         errors++; $display("[TB] FAIL midrst_no_write got %0d/%0d want 0/0", recsA.size(), recsB.size()); end
      startLine(1'b1, 5'd2);
      sendOpt(3'b011, 1'b1);
      waitIdle();
      checks++; if ((recsA.size() > 0 ? recsA[0] : '0) !== 1024'h6045) begin
         errors++; $display("[TB] FAIL midrst_record_a got %h want 6045", (recsA.size() > 0 ? recsA[0] : '0)); end
      checks++; if ((recsB.size() > 0 ? recsB[0] : '0) !== 32'h645 || ifB.overflow !== 1'b0) begin
         errors++; $display("[TB] FAIL midrst_record_b got %h ovf %b want 00000645 0", (recsB.size() > 0 ? recsB[0] : '0), ifB.overflow); end
   endtask

   task automatic test_back_to_back();
      recsA.delete(); recsB.delete();
      startLine(1'b0, 5'd0);
      sendOpt(3'b110, 1'b0);
      sendOpt(3'b101, 1'b1);
      startLine(1'b1, 5'd2);
      checks++; if (ifA.opt_count !== 7'd0 || ifA.busy !== 1'b1) begin
         errors++; $display("[TB] FAIL b2b_restart got count %0d busy %b want 0 1", ifA.opt_count, ifA.busy); end
      sendOpt(3'b111, 1'b1);
      waitIdle();
      checks++; if (recsA.size() !== 2 || recsB.size() !== 2) begin
         errors++; $display("[TB] FAIL b2b_wr_pulses got %0d/%0d want 2/2", recsA.size(), recsB.size()); end
      checks++; if ((recsA.size() > 0 ? recsA[0] : '0) !== 1024'h5C080) begin
         errors++; $display("[TB] FAIL b2b_first_a got %h want 5c080", (recsA.size() > 0 ? recsA[0] : '0)); end
      checks++; if ((recsA.size() > 1 ? recsA[1] : '0) !== 1024'hE045) begin
         errors++; $display("[TB] FAIL b2b_second_a got %h want e045", (recsA.size() > 1 ? recsA[1] : '0)); end
      checks++; if ((recsB.size() > 1 ? {recsB[0], recsB[1]} : 64'd0) !== {32'h5C80, 32'hE45}) begin
         errors++; $display("[TB] FAIL b2b_records_b got %h want 00005c8000000e45", (recsB.size() > 1 ? {recsB[0], recsB[1]} : 64'd0)); end
   endtask

`ifdef PACKER_KNOWN_FILTER_EN
   task automatic test_known_filter();
      recsA.delete(); recsB.delete();
      knownMask = 3'b010; knownVal = 3'b010;
      startLine(1'b1, 5'd4);
      knownMask = 3'b000; knownVal = 3'b000;
      sendOpt(3'b000, 1'b0);
      sendOpt(3'b010, 1'b0);
      sendOpt(3'b011, 1'b1);
      waitIdle();
      checks++; if (ifA.opt_count !== 7'd2) begin
         errors++; $display("[TB] FAIL filter_count got %0d want 2", ifA.opt_count); end
      checks++; if ((recsA.size() > 0 ? recsA[0] : '0) !== 1024'h34089) begin
         errors++; $display("[TB] FAIL filter_record_a got %h want 34089", (recsA.size() > 0 ? recsA[0] : '0)); end
      checks++; if ((recsB.size() > 0 ? recsB[0] : '0) !== 32'h3489) begin
         errors++; $display("[TB] FAIL filter_record_b got %h want 00003489", (recsB.size() > 0 ? recsB[0] : '0)); end
   endtask
`endif

   initial begin
      $display("[TB] line_record_packer directed run");
      test_reset();
      test_basic();
      test_backpressure();
      test_overflow();
      test_reset_mid();
      test_back_to_back();
`ifdef PACKER_KNOWN_FILTER_EN
      test_known_filter();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
